// File: rtl/ecg_delta_encoder_if.sv
// Purpose: bundles the sample input handshake and the spike/address/ack event port of ecg_delta_encoder.
// Latency: none, wires only.
// Backpressure: sample_ready gates samples; ack_in pops the head event.
// Ports: sample_in/sample_valid/sample_ready (sample stream), spike_out/address_out/ack_in (event stream).
// master = sample producer and event consumer; slave = the encoder.
interface ecg_delta_encoder_if #(
    parameter int SAMPLE_W = 12
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;
    logic                spike_out;
    logic [3:0]          address_out;
    logic                ack_in;

    modport master (
        output sample_in, sample_valid, ack_in,
        input  sample_ready, spike_out, address_out
    );

    modport slave (
        input  sample_in, sample_valid, ack_in,
        output sample_ready, spike_out, address_out
    );
endinterface

// File: rtl/ecg_delta_encoder.sv
// Purpose: level-crossing (delta) encoder turning ECG samples into 4-bit {up, band} address events.
// Latency: sample accepted at edge N -> first event pushed at edge N+1 -> spike_out from cycle N+2; one crossing per cycle.
// Backpressure: a full FIFO without a pop stalls crossing (no drops); sample_ready is low until crossings finish.
// Ports: clk, resetn (synchronous, active-low); bus.slave carries sample_in/sample_valid/sample_ready
//        and spike_out/address_out/ack_in.
module ecg_delta_encoder #(
    parameter int SAMPLE_W   = 12,
    parameter int DELTA      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    ecg_delta_encoder_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [SAMPLE_W-1:0]        STEP    = SAMPLE_W'(DELTA);
    localparam logic signed [SAMPLE_W:0]   DELTA_P = $signed((SAMPLE_W+1)'(DELTA));
    localparam logic signed [SAMPLE_W:0]   DELTA_N = -DELTA_P;
    localparam logic [CNT_W-1:0]           FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, CROSS} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] ref_q;
    logic [SAMPLE_W-1:0] target_q;
    logic                init_q;

    logic [3:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [CNT_W-1:0]    count;

    logic signed [SAMPLE_W:0] diff;
    logic                up_step, dn_step;
    logic                spike, pop, can_push, push, accept;
    logic [SAMPLE_W-1:0] ref_next;
    logic [3:0]          push_dat;

    // Both operands zero-extended so the difference is exact in SAMPLE_W+1 signed bits.
    assign diff     = $signed({1'b0, target_q}) - $signed({1'b0, ref_q});
    assign up_step  = (diff >= DELTA_P);
    assign dn_step  = (diff <= DELTA_N);

    assign spike    = (count != '0);
    assign pop      = bus.ack_in && spike;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign can_push = (count != FULL_CNT) || pop;
    assign push     = (state_q == CROSS) && (up_step || dn_step) && can_push;
    assign accept   = (state_q == IDLE) && bus.sample_valid;

    // Band comes from the reference after the step, not before it.
    assign ref_next = up_step ? (ref_q + STEP) : (ref_q - STEP);
    assign push_dat = {up_step, ref_next[SAMPLE_W-1 -: 3]};

    assign bus.sample_ready = (state_q == IDLE);
    assign bus.spike_out    = spike;
    assign bus.address_out  = spike ? fifo_mem[rd_ptr] : 4'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // The very first sample only seeds the reference.
                if (accept && init_q) begin
                    state_d = CROSS;
                end
            end
            CROSS: begin
                // Residual below one step stays in ref; a stalled push keeps us here.
                if (!up_step && !dn_step) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ref_q    <= '0;
            target_q <= '0;
            init_q   <= 1'b0;
        end else begin
            if (accept) begin
                if (!init_q) begin
                    ref_q  <= bus.sample_in;
                    init_q <= 1'b1;
                end else begin
                    target_q <= bus.sample_in;
                end
            end
            if (push) begin
                ref_q <= ref_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: address_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// File: doc/ecg_delta_encoder.md
# ecg_delta_encoder

Converts a stream of ECG samples into address-event spikes for one input port of a hidden-layer neuron. It uses level-crossing (delta) encoding: each time the signal moves a full DELTA step away from a tracked reference, it emits one event. The 4-bit event address carries polarity and amplitude band, so the downstream weight ROM can select a per-band, per-direction synapse. Events are buffered in a small FIFO and presented on a spike/address/ack handshake that matches the hidden neuron's per-port interface.

## Interface
- SAMPLE_W, 12: sample width, unsigned. Minimum 4.
- DELTA, 16: crossing step in LSBs. Range 1 to 2^(SAMPLE_W-1).
- FIFO_DEPTH, 4: event FIFO entries. Power of 2, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- sample_in  in  SAMPLE_W  unsigned ECG sample.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  encoder accepts a sample this cycle. Equals (state==IDLE).
- spike_out  out  1  event pending. High exactly when the FIFO is non-empty.
- address_out  out  4  head event address = {up, band[2:0]}. Value is 0 when the FIFO is empty.
- ack_in  in  1  consumer accepted the head event.

## Operation
- Registers:
  - ref (SAMPLE_W bits)
  - target (SAMPLE_W bits)
  - init flag
  - state in {IDLE, CROSS}
  - FIFO of 4-bit entries, with read/write pointers and a count.
- IDLE:
  - sample_ready=1.
  - On sample_valid with init=0: set ref=sample_in and init=1. No event. Stay in IDLE.
  - On sample_valid with init=1: set target=sample_in and go to CROSS.
- CROSS, evaluated each cycle, with diff = target - ref (signed, SAMPLE_W+1 bits):
  - If diff >= DELTA and the FIFO can accept: ref += DELTA; push {1, new_ref[SAMPLE_W-1:SAMPLE_W-3]}.
  - If diff <= -DELTA and the FIFO can accept: ref -= DELTA; push {0, new_ref[SAMPLE_W-1:SAMPLE_W-3]}.
  - If |diff| < DELTA: go to IDLE. Residual stays in ref, with no rounding.
  - If a push is required but the FIFO cannot accept: hold. ref, state and FIFO are unchanged. Events are never dropped.
- FIFO can accept when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs this cycle (push and pop on a full FIFO are allowed).
- Pop occurs when ack_in && spike_out. ack_in while empty is ignored.
- ref arithmetic cannot wrap, because target lies in range and |diff| >= DELTA before every step.
- band is taken from the updated ref, not the old one.

## Timing
- Reset values:
  - sample_ready=1, spike_out=0, address_out=0
  - state=IDLE, init=0, ref=0, target=0
  - FIFO empty, pointers 0.
- Reset asserted mid-CROSS or with events pending discards all pending events. The next cycle's outputs equal the reset values.
- Sample accepted at edge N (valid&&ready): state=CROSS during cycle N+1.
- The first push happens at edge N+1, so spike_out=1 from cycle N+2.
- One crossing per cycle while not stalled. k crossings finish at edge N+k. The cycle N+k+1 evaluates |diff|<DELTA, so sample_ready=1 from cycle N+k+2.
- Zero-crossing sample: sample_ready is low for exactly 1 cycle (N+1).
- address_out is valid in the same cycle that spike_out is high. After a pop at edge M, the next entry is visible in cycle M+1.
- With ack_in held high, one event drains per cycle. Sustained throughput is 1 event/cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Test plan
Defaults are SAMPLE_W=12, DELTA=16, FIFO_DEPTH=4.

1. Reset, then sample 2048 → no spike. ref=2048. sample_ready high again the next cycle.
2. Next sample 2100 with ack_in=1 → 3 events, all 4'hC (refs 2064/2080/2096, band 4). Final ref=2096. First spike_out 2 cycles after acceptance.
3. Next sample 2000 with ack_in=0 → FIFO fills with 4'h4, 4'h4, 4'h4, 4'h3. spike_out=1. Encoder stalls with sample_ready=0. Then raise ack_in → remaining 4'h3, 4'h3 pass through. Final ref=2000. 6 events total, in order.
4. Sample 2015 from ref 2000 (diff 15) → no event. sample_ready low for exactly 1 cycle.
5. Ref 0, then sample 4095 with ack_in=1 → 255 UP events. The last is 4'hF with ref=4080. No wrap.
6. resetn low during CROSS with 3 events queued → next cycle: spike_out=0, address_out=0, sample_ready=1. The next sample only re-initialises ref.
